// File: rtl/uart_reg_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_cmd_ctrl
// Description : Command sequencer between the UART byte RX/TX pair and the
//               internal register bus. Parses write (A5 addr dh dl) and read
//               (5A addr) frames and issues one register access per frame.
//               Sends response frames back one byte per TX handshake: 4B for
//               a write, 52 dh dl for a read, EE on error.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_cmd_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int GAP_CLKS   = 108500,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // UART receiver side
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    // UART transmitter side
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    // Register bus master
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    // Status
    output logic              busy,
    output logic              err_pulse
);

    // ------------------------------------------------------------------------
    // Frame and response byte codes
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_CMD_WR  = 8'hA5;
    localparam logic [7:0] c_CMD_RD  = 8'h5A;
    localparam logic [7:0] c_RSP_WR  = 8'h4B;
    localparam logic [7:0] c_RSP_RD  = 8'h52;
    localparam logic [7:0] c_RSP_ERR = 8'hEE;

    // Counter widths sized so the terminal value always fits
    localparam int c_GAP_W = $clog2(GAP_CLKS + 1);
    localparam int c_TO_W  = $clog2(RD_TIMEOUT + 1);

    // The gap counter holds the number of idle clocks already seen; reaching
    // GAP_CLKS-1 with yet another idle clock means GAP_CLKS have elapsed.
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CLKS - 1);
    // The read timer starts at 1 in the strobe cycle itself, so the check
    // against RD_TIMEOUT-1 fires on the RD_TIMEOUT-th clock after reg_rd_en.
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(RD_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_DHI     = 4'd2,
        S_DLO     = 4'd3,
        S_WR      = 4'd4,
        S_RD      = 4'd5,
        S_RD_WAIT = 4'd6,
        S_TX_SEND = 4'd7,
        S_TX_WAIT = 4'd8
    } state_t;

    state_t              r_state;
    logic                r_is_read;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;

    // Response frame: first byte plus captured read data for bytes 1 and 2
    logic [7:0]          r_resp_code;
    logic [DATA_W-1:0]   r_rdata_cap;
    logic [1:0]          r_tx_len;
    logic [1:0]          r_tx_idx;

    // Registered outputs
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic                r_wr_en;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;

    logic [1:0]          w_idx_next;
    logic [7:0]          w_next_byte;
    logic                w_gap_hit;
    logic                w_to_hit;

    assign w_idx_next = r_tx_idx + 2'd1;
    assign w_gap_hit  = (r_gap_cnt == c_GAP_LAST);
    assign w_to_hit   = (r_to_cnt >= c_TO_LAST);

    // Select the response byte that follows the one just acknowledged
    always_comb begin
        w_next_byte = r_resp_code;
        case (w_idx_next)
            2'd1:    w_next_byte = r_rdata_cap[DATA_W-1 -: 8];
            2'd2:    w_next_byte = r_rdata_cap[7:0];
            default: w_next_byte = r_resp_code;
        endcase
    end

    // Main sequencer: frame parsing, register access and response serialising
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_resp_code <= 8'h00;
            r_rdata_cap <= '0;
            r_tx_len    <= 2'd0;
            r_tx_idx    <= 2'd0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            // Strobes and pulses default low; each is raised for one cycle
            r_tx_valid <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_gap_cnt <= '0;
                        if (rx_data == c_CMD_WR) begin
                            r_is_read <= 1'b0;
                            r_state   <= S_ADDR;
                        end else if (rx_data == c_CMD_RD) begin
                            r_is_read <= 1'b1;
                            r_state   <= S_ADDR;
                        end else begin
                            // Unknown command: single-byte error response
                            r_resp_code <= c_RSP_ERR;
                            r_tx_len    <= 2'd1;
                            r_tx_idx    <= 2'd0;
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= c_RSP_ERR;
                            r_err       <= 1'b1;
                            r_state     <= S_TX_SEND;
                        end
                    end
                end

                S_ADDR: begin
                    if (rx_valid) begin
                        r_gap_cnt <= '0;
                        r_addr    <= rx_data[ADDR_W-1:0];
                        if (r_is_read) begin
                            r_rd_en  <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_RD;
                        end else begin
                            r_state  <= S_DHI;
                        end
                    end else if (w_gap_hit) begin
                        // Host stalled mid-frame: drop the frame silently
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_DHI: begin
                    if (rx_valid) begin
                        r_gap_cnt                <= '0;
                        r_wdata[DATA_W-1 -: 8]   <= rx_data;
                        r_state                  <= S_DLO;
                    end else if (w_gap_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_DLO: begin
                    if (rx_valid) begin
                        // Write strobe goes out the very next clock
                        r_gap_cnt     <= '0;
                        r_wdata[7:0]  <= rx_data;
                        r_wr_en       <= 1'b1;
                        r_state       <= S_WR;
                    end else if (w_gap_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_WR: begin
                    r_resp_code <= c_RSP_WR;
                    r_tx_len    <= 2'd1;
                    r_tx_idx    <= 2'd0;
                    r_tx_valid  <= 1'b1;
                    r_tx_data   <= c_RSP_WR;
                    r_state     <= S_TX_SEND;
                end

                S_RD: begin
                    r_to_cnt <= c_TO_W'(1);
                    r_state  <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    // Data is checked first so a late rvalid on the expiry
                    // clock still produces a data response
                    if (reg_rvalid) begin
                        r_rdata_cap <= reg_rdata;
                        r_resp_code <= c_RSP_RD;
                        r_tx_len    <= 2'd3;
                        r_tx_idx    <= 2'd0;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= c_RSP_RD;
                        r_state     <= S_TX_SEND;
                    end else if (w_to_hit) begin
                        r_resp_code <= c_RSP_ERR;
                        r_tx_len    <= 2'd1;
                        r_tx_idx    <= 2'd0;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= c_RSP_ERR;
                        r_err       <= 1'b1;
                        r_state     <= S_TX_SEND;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_TX_SEND: begin
                    r_state <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (tx_done) begin
                        if (w_idx_next == r_tx_len) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_tx_idx   <= w_idx_next;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_next_byte;
                            r_state    <= S_TX_SEND;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign reg_wr_en = r_wr_en;
    assign reg_rd_en = r_rd_en;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign err_pulse = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_reg_cmd_ctrl.md
Name: uart_reg_cmd_ctrl

Overview:
Command sequencer between the board's UART byte receiver/transmitter and the internal register bus. It parses fixed-format command frames from the RX byte stream and issues single register writes and reads. It then serialises response frames back through the TX byte interface, one byte per TX handshake. It is the only master of the register bus inside the register interface and sits directly behind the uart_rx/uart_tx instances.

Parameters:
ADDR_W, 8, register address width; address is taken from one frame byte, so the width is fixed at 8.
DATA_W, 16, register data width; sent as two bytes, MSB first.
GAP_CLKS, 108500, maximum idle clocks between RX bytes of one frame before abort (about 10 byte-times at 125MHz/115200).
RD_TIMEOUT, 255, maximum clocks to wait for reg_rvalid after reg_rd_en.

Ports:
clk  in  1  system clock, 125MHz
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle pulse; rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  one-cycle pulse; launches tx_data
tx_data  out  8  byte to transmit; held stable until the next tx_valid
tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
reg_wr_en  out  1  one-cycle register write strobe
reg_rd_en  out  1  one-cycle register read strobe
reg_addr  out  8  register address; valid with either strobe
reg_wdata  out  16  write data; valid with reg_wr_en
reg_rdata  in  16  read data; sampled when reg_rvalid is high
reg_rvalid  in  1  read data valid; arrives 1 or more clocks after reg_rd_en
busy  out  1  high in any state other than IDLE
err_pulse  out  1  one-cycle pulse on bad command, gap timeout or read timeout

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE, and the gap and timeout counters clear. rst asserted mid-frame or mid-response discards everything immediately. No TX byte is sent after reset until a new command completes.
- Frame formats:
  - Write: 0xA5, addr, data[15:8], data[7:0].
  - Read: 0x5A, addr.
- Response formats:
  - Write: 0x4B.
  - Read: 0x52, rdata[15:8], rdata[7:0].
  - Error: 0xEE.
- FSM states: IDLE, ADDR, DHI, DLO, WR, RD, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE, on rx_valid:
  - 0xA5 -> ADDR, with a write flag.
  - 0x5A -> ADDR, with a read flag.
  - Any other byte -> load the 1-byte response 0xEE, pulse err_pulse, go to TX_SEND.
- ADDR: on rx_valid, latch reg_addr. Write flag -> DHI; read flag -> RD.
- DHI, DLO: latch the data bytes, MSB first. DLO on rx_valid -> WR.
- WR: one cycle. reg_wr_en=1 with reg_addr and reg_wdata stable. Load response 0x4B and go to TX_SEND. Latency from the last RX byte to reg_wr_en is exactly 1 clock.
- RD: one cycle with reg_rd_en=1, then RD_WAIT.
- RD_WAIT:
  - On reg_rvalid: capture reg_rdata, load the 3-byte response, go to TX_SEND.
  - After RD_TIMEOUT clocks without reg_rvalid: load 0xEE, pulse err_pulse, go to TX_SEND.
  - reg_rvalid in the same cycle as the timeout expiry counts as valid (data wins).
- Gap timer: counts clocks in ADDR/DHI/DLO and resets on every rx_valid. When it reaches GAP_CLKS: pulse err_pulse, return to IDLE, send no response.
- TX_SEND: one cycle with tx_valid=1 and tx_data=buf[idx], then TX_WAIT.
- TX_WAIT: on tx_done, increment idx.
  - idx == length: go to IDLE.
  - Otherwise: go to TX_SEND.
  - The next tx_valid comes exactly 1 clock after tx_done.
- RX during WR/RD/RD_WAIT/TX_SEND/TX_WAIT: the byte is dropped, not buffered, and does not affect the FSM. The host must wait for the full response before sending the next frame.
- tx_done outside TX_WAIT is ignored. reg_rvalid outside RD_WAIT is ignored.
- The register strobes are never asserted together, and never more than once per frame.

Test Plan:
- Write frame A5 10 12 34, bytes 20 clocks apart -> one reg_wr_en pulse with addr=0x10 and wdata=0x1234, 1 clock after the last byte. TX then sends 0x4B, and busy falls after its tx_done.
- Read frame 5A 22, reg_rvalid 3 clocks after reg_rd_en with rdata=0xBEEF -> TX sends 52, BE, EF in order. Each tx_valid comes 1 clock after the previous tx_done.
- Bad command byte 0x33 -> err_pulse, TX sends 0xEE, no register strobe. A following valid write then completes normally.
- Partial frame A5 10, then silence for more than GAP_CLKS (override to 100) -> err_pulse at clock 100, back to IDLE, no TX and no strobe. Then 5A 22 reads correctly.
- Read with reg_rvalid never asserted (RD_TIMEOUT=16) -> err_pulse 16 clocks after reg_rd_en and TX sends 0xEE. Repeat with reg_rvalid exactly at the expiry cycle -> the 3-byte data response is sent.
- Extra RX byte injected while TX_WAIT, and rst asserted mid-read response after the first byte -> the extra byte is ignored. On reset, all outputs read 0 the next cycle, no further tx_valid appears, and a subsequent A5 01 00 01 write succeeds.
